// File: rtl/soc_system_avmm_pio_master.sv
// Avalon-MM initiator for soc_system PIO-style slaves. The slave has no waitrequest
// and a fixed read latency. The block takes one command at a time on a
// valid/ready port: write, read, or poll-until-match with a timeout. Each command
// produces exactly one single-cycle response.
module soc_system_avmm_pio_master #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 2,
    parameter int READ_LATENCY = 1,
    parameter int POLL_TIMEOUT = 1024,
    parameter int POLL_GAP     = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    // command port
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [DATA_W-1:0] cmd_mask,
    // Avalon-MM initiator
    output logic [ADDR_W-1:0] address,
    output logic              chipselect,
    output logic              write_n,
    output logic [DATA_W-1:0] writedata,
    input  logic [DATA_W-1:0] readdata,
    // response port
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        rsp_status,
    output logic              busy
);

    typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_WAIT, GAP, RSP} state_t;
    typedef enum logic [1:0] {OP_WRITE = 2'd0, OP_READ = 2'd1, OP_POLL = 2'd2, OP_ILLEGAL = 2'd3} op_t;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_TIMEOUT = 2'd1;
    localparam logic [1:0] ST_BAD_OP  = 2'd2;

    state_t            state, next_state;
    op_t               lat_op;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] lat_mask;

    // cnt is shared between the read-latency wait and the poll gap. Only one of
    // those two waits is active at any time.
    logic [15:0]       cnt, cnt_next;
    logic [15:0]       attempts, attempts_next, attempts_inc;

    logic              accept;
    logic              rsp_load;
    logic [DATA_W-1:0] rsp_data_next;
    logic [1:0]        rsp_status_next;
    logic              poll_match;
    logic              issue_access;

    assign cmd_ready    = (state == IDLE);
    assign busy         = (state != IDLE);
    assign attempts_inc = attempts + 16'd1;
    assign poll_match   = ((readdata ^ lat_wdata) & lat_mask) == '0;
    assign issue_access = (next_state == WR) || (next_state == RD_ADDR);

    // Next-state, counter and response decode.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case can infer a latch.
        next_state      = state;
        cnt_next        = cnt;
        attempts_next   = attempts;
        accept          = 1'b0;
        rsp_load        = 1'b0;
        rsp_data_next   = '0;
        rsp_status_next = ST_OK;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    accept        = 1'b1;
                    attempts_next = '0;
                    case (op_t'(cmd_op))
                        OP_WRITE:         next_state = WR;
                        OP_READ, OP_POLL: next_state = RD_ADDR;
                        default: begin
                            next_state      = RSP;
                            rsp_load        = 1'b1;
                            rsp_status_next = ST_BAD_OP;
                        end
                    endcase
                end
            end

            WR: begin
                next_state = RSP;
                rsp_load   = 1'b1;
            end

            RD_ADDR: begin
                next_state = RD_WAIT;
                cnt_next   = 16'(READ_LATENCY - 1);
            end

            RD_WAIT: begin
                if (cnt != '0) begin
                    cnt_next = cnt - 16'd1;
                end else if (lat_op == OP_READ) begin
                    next_state    = RSP;
                    rsp_load      = 1'b1;
                    rsp_data_next = readdata;
                end else begin
                    attempts_next = attempts_inc;
                    if (poll_match) begin
                        next_state    = RSP;
                        rsp_load      = 1'b1;
                        rsp_data_next = readdata;
                    end else if (attempts_inc == 16'(POLL_TIMEOUT)) begin
                        next_state      = RSP;
                        rsp_load        = 1'b1;
                        rsp_data_next   = readdata;
                        rsp_status_next = ST_TIMEOUT;
                    end else if (POLL_GAP == 0) begin
                        next_state = RD_ADDR;
                    end else begin
                        next_state = GAP;
                        cnt_next   = 16'(POLL_GAP - 1);
                    end
                end
            end

            GAP: begin
                if (cnt == '0) next_state = RD_ADDR;
                else           cnt_next   = cnt - 16'd1;
            end

            RSP:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State, command latch and registered Avalon/response outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: everything here is a flop and is assigned non-blocking. There are no
        // memories, so every register can be reset and an abort leaves no stale state.
        if (!reset_n) begin
            state      <= IDLE;
            lat_op     <= OP_WRITE;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_mask   <= '0;
            cnt        <= '0;
            attempts   <= '0;
            address    <= '0;
            chipselect <= 1'b0;
            write_n    <= 1'b1;
            writedata  <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_status <= ST_OK;
        end else begin
            state    <= next_state;
            cnt      <= cnt_next;
            attempts <= attempts_next;

            if (accept) begin
                lat_op    <= op_t'(cmd_op);
                lat_addr  <= cmd_addr;
                lat_wdata <= cmd_wdata;
                lat_mask  <= cmd_mask;
            end

            // Avalon strobes are registered from next_state. They are therefore
            // glitch-free, and they are active exactly during the WR and RD_ADDR cycles.
            chipselect <= issue_access;
            write_n    <= (next_state != WR);
            if (issue_access) address <= accept ? cmd_addr : lat_addr;
            if (next_state == WR) writedata <= cmd_wdata;

            rsp_valid <= rsp_load;
            if (rsp_load) begin
                rsp_data   <= rsp_data_next;
                rsp_status <= rsp_status_next;
            end
        end
    end

endmodule
